// File: rtl/seq_mem_stream_pkg.sv
// Shared types for the seq_mem_d1 stream reader: controller states and the depth of the output buffer.
package seq_mem_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STREAM_FIFO_DEPTH = 3;

endpackage

// File: rtl/seq_mem_stream_fifo.sv
// Three-entry output buffer for the stream reader. Head word is presented on data; when the buffer
// is empty, data reads as zero.
module seq_mem_stream_fifo
  import seq_mem_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] entries [STREAM_FIFO_DEPTH];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'(STREAM_FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign empty = (count == 2'd0);
  assign data  = empty ? '0 : entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!reset && push && !pop && count == 2'(STREAM_FIFO_DEPTH))
      $error("seq_mem_stream_fifo: overflow");
    if (!reset && pop && empty)
      $error("seq_mem_stream_fifo: underflow");
  end

endmodule

// File: rtl/seq_mem_d1_stream_reader.sv
// Reads len words from a seq_mem_d1 port starting at base (wrapping mod SIZE) and streams them out
// on valid/ready, pulsing done once every word has been consumed.
//   state | meaning
//   IDLE  | waiting for go; base/len latched when go is seen
//   BUSY  | issuing reads under credit control and draining the buffer
//   DONE  | single-cycle done pulse, go ignored
module seq_mem_d1_stream_reader
  import seq_mem_stream_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4,
  parameter int LEN_SIZE = IDX_SIZE + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] base,
  input  logic [LEN_SIZE-1:0] len,
  output logic                done,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic                mem_read_en,
  input  logic [WIDTH-1:0]    mem_out,
  input  logic                mem_read_done,
  output logic                mem_write_en,
  output logic [WIDTH-1:0]    mem_in,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  state_t              state;
  logic [IDX_SIZE-1:0] addr;
  logic [LEN_SIZE-1:0] len_q;
  logic [LEN_SIZE-1:0] issue_cnt;
  logic [LEN_SIZE-1:0] pop_cnt;
  logic                inflight;
  logic [1:0]          fifo_count;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                credit_ok;

  // A read is only issued if the buffer can still absorb it together with any word already in flight.
  assign credit_ok    = ({1'b0, fifo_count} + {2'b00, inflight}) < 3'(STREAM_FIFO_DEPTH);
  assign mem_read_en  = !reset && (state == BUSY) && (issue_cnt < len_q) && credit_ok;
  assign mem_addr0    = addr;
  assign mem_write_en = 1'b0;
  assign mem_in       = '0;

  assign push      = mem_read_done && inflight;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign done      = (state == DONE);

  seq_mem_stream_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mem_out),
    .pop       (pop),
    .data      (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= mem_read_en;
      case (state)
        IDLE: begin
          if (go) begin
            addr      <= base;
            len_q     <= len;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            state     <= (len == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (mem_read_en) begin
            issue_cnt <= issue_cnt + LEN_SIZE'(1);
            addr      <= (addr == IDX_SIZE'(SIZE - 1)) ? '0 : addr + IDX_SIZE'(1);
          end
          if (pop) begin
            pop_cnt <= pop_cnt + LEN_SIZE'(1);
            // Finish on the handshake that consumes the last word so done lands the cycle after.
            if (pop_cnt + LEN_SIZE'(1) == len_q) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!reset && state == IDLE && go && 32'(base) >= 32'(SIZE))
      $error("seq_mem_d1_stream_reader: base out of range");
  end

endmodule
